alu_share_arbiter: RTL

//  Shares one 64-bit ALU_wrapper instance among NREQ requesters (e.g. execute

---
 rtl/alu_share_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Time-shares one 64-bit ALU_wrapper among NREQ requesters. A round-robin
//   arbiter picks one valid requester while idle. Its operands are registered
//   and drive the ALU for one full cycle. The ALU result is captured into a
//   response register, which is then offered on a valid/ready handshake.
//   Sequence: IDLE -> EXEC -> RESP -> IDLE.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   IDW   width of rsp_id / grant index; must be able to hold NREQ-1
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/ready     per-requester request handshake (ready is one-hot or 0)
//   req_ctrl/a/b        packed per-requester op (2b) and operands (64b each)
//   rsp_valid/ready     response handshake
//   rsp_id              index of the requester that owns the response
//   rsp_result, rsp_cc  ALU result and {ZF,SF,OF}
//   alu_control/a/b     registered operands driven to the ALU_wrapper
//   alu_out, alu_of     result and overflow returned by the ALU_wrapper
//
// Configuration:
//   ALU_ARB_CC_EN  defined   -> {ZF,SF,OF} captured with the result and held
//                               until the next capture.
//                  undefined -> no flag logic; rsp_cc is constant 3'b000.
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_ctrl,
  input  logic [64*NREQ-1:0] req_a,
  input  logic [64*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [63:0]       rsp_result,
  output logic [2:0]        rsp_cc,
  output logic [1:0]        alu_control,
  output logic [63:0]       alu_a,
  output logic [63:0]       alu_b,
  input  logic [63:0]       alu_out,
  input  logic              alu_of
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic [63:0]     a_q, a_d;
  logic [63:0]     b_q, b_d;
  logic [63:0]     result_q, result_d;

  // Unpacked views of the per-requester request buses.
  logic [1:0]  ctrl_arr [NREQ];
  logic [63:0] a_arr    [NREQ];
  logic [63:0] b_arr    [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign ctrl_arr[gi] = req_ctrl[2*gi +: 2];
    assign a_arr[gi]    = req_a[64*gi +: 64];
    assign b_arr[gi]    = req_b[64*gi +: 64];
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid requester starting just after the last
  // grant, wrapping at NREQ. The offset walk keeps the priority rotation
  // explicit and avoids a modulo on a non-power-of-two NREQ.
  // ---------------------------------------------------------------------------
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  int             scan_idx;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = int'(last_grant_q) + k;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(scan_idx);
      end
    end
  end

  // Request accept happens only while idle; rst_n gating keeps a requester
  // from seeing a handshake that the reset edge is about to discard.
  logic accept;
  assign accept = (state_q == S_IDLE) && grant_found && rst_n;

`ifdef ALU_ARB_CC_EN
  logic [2:0] cc_q, cc_d;
  logic       cap_of;
  // Logical ops never overflow, whatever the ALU reports on its OF pin.
  assign cap_of = (ctrl_q[1] == 1'b0) ? alu_of : 1'b0;
`else
  logic unused_alu_of;
  assign unused_alu_of = alu_of;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      ctrl_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
`ifdef ALU_ARB_CC_EN
      cc_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      ctrl_q       <= ctrl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
`ifdef ALU_ARB_CC_EN
      cc_q         <= cc_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath register updates. Operand registers only change
  // on an accept, so the ALU inputs do not toggle in IDLE or RESP.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    ctrl_d       = ctrl_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
`ifdef ALU_ARB_CC_EN
    cc_d         = cc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ctrl_d       = ctrl_arr[grant_idx];
          a_d          = a_arr[grant_idx];
          b_d          = b_arr[grant_idx];
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_out;
`ifdef ALU_ARB_CC_EN
        cc_d     = {(alu_out == 64'd0), alu_out[63], cap_of};
`endif
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = accept && (grant_idx == IDW'(gi));
  end

  always_comb begin
    rsp_valid   = (state_q == S_RESP);
    rsp_id      = id_q;
    rsp_result  = result_q;
    alu_control = ctrl_q;
    alu_a       = a_q;
    alu_b       = b_q;
`ifdef ALU_ARB_CC_EN
    rsp_cc      = cc_q;
`else
    rsp_cc      = 3'b000;
`endif
  end

endmodule
